fpnew_rob_issuer: RTL and testbench

- Initiator/collector that sits between a core's FP dispatch stage and the FPU top.
- Issues operations into the FPU input handshake and assigns each one a reorder-slot index as its tag.
- Accepts results out of order from the FPU output handshake, which comes from the round-robin opgroup arbiter.
- Returns results to the core strictly in issue order, with the core's user tag restored.

---
 rtl/fpnew_rob_issuer.sv | 160 ++++++++++++++++
 tb/tb_fpnew_rob_issuer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_rob_issuer.sv
// Reorder-buffer issuer between an FP dispatch stage and the FPU: tags each op with its slot, collects
// out-of-order results and returns them in issue order. Optional same-cycle head bypass: FPNEW_ROB_BYPASS_EN.
module fpnew_rob_issuer #(
   parameter int unsigned Width       = 64,
   parameter int unsigned NumOperands = 3,
   parameter int unsigned Depth       = 4,
   parameter int unsigned UserWidth   = 5,
   parameter int unsigned TagWidth    = $clog2(Depth)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   // Core request
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [NumOperands*Width-1:0] req_operands_i,
   input  logic [2:0]                   req_rnd_mode_i,
   input  logic [3:0]                   req_op_i,
   input  logic                         req_op_mod_i,
   input  logic [2:0]                   req_src_fmt_i,
   input  logic [2:0]                   req_dst_fmt_i,
   input  logic [1:0]                   req_int_fmt_i,
   input  logic                         req_vectorial_i,
   input  logic [UserWidth-1:0]         req_user_i,
   // FPU input side
   output logic                         fpu_valid_o,
   input  logic                         fpu_ready_i,
   output logic [NumOperands*Width-1:0] fpu_operands_o,
   output logic [2:0]                   fpu_rnd_mode_o,
   output logic [3:0]                   fpu_op_o,
   output logic                         fpu_op_mod_o,
   output logic [2:0]                   fpu_src_fmt_o,
   output logic [2:0]                   fpu_dst_fmt_o,
   output logic [1:0]                   fpu_int_fmt_o,
   output logic                         fpu_vectorial_o,
   output logic [TagWidth-1:0]          fpu_tag_o,
   output logic                         fpu_flush_o,
   // FPU output side
   input  logic                         fpu_out_valid_i,
   output logic                         fpu_out_ready_o,
   input  logic [Width-1:0]             fpu_result_i,
   input  logic [4:0]                   fpu_status_i,
   input  logic [TagWidth-1:0]          fpu_tag_i,
   // In-order response
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [Width-1:0]             rsp_result_o,
   output logic [4:0]                   rsp_status_o,
   output logic [UserWidth-1:0]         rsp_user_o,
   output logic                         busy_o,
   output logic                         spurious_o
);

   localparam int unsigned CntW = TagWidth + 1;

   // Handshakes: a transfer happens on a cycle where valid and ready are both high at the clock edge.
   logic [TagWidth-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [Depth-1:0]     alloc_q, done_q;
   logic                 spurious_q;
   logic [Width-1:0]     result_q [Depth];
   logic [4:0]           status_q [Depth];
   logic [UserWidth-1:0] user_q   [Depth];

   logic full, issue, slot_open, res_hit, res_bad, head_ready, bypass, retire, store;

   assign full        = (count_q == CntW'(Depth));
   assign fpu_valid_o = req_valid_i & ~full;
   assign req_ready_o = fpu_valid_o & fpu_ready_i;
   assign issue       = req_ready_o & ~flush_i;

   assign fpu_operands_o  = req_operands_i;
   assign fpu_rnd_mode_o  = req_rnd_mode_i;
   assign fpu_op_o        = req_op_i;
   assign fpu_op_mod_o    = req_op_mod_i;
   assign fpu_src_fmt_o   = req_src_fmt_i;
   assign fpu_dst_fmt_o   = req_dst_fmt_i;
   assign fpu_int_fmt_o   = req_int_fmt_i;
   assign fpu_vectorial_o = req_vectorial_i;
   assign fpu_tag_o       = tail_q;
   assign fpu_flush_o     = flush_i;

   // Slots are reserved at issue, so a result can always be absorbed.
   assign fpu_out_ready_o = 1'b1;
   assign slot_open       = alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i];
   assign res_hit         = fpu_out_valid_i & ~flush_i & slot_open;
   assign res_bad         = fpu_out_valid_i & ~flush_i & ~slot_open;
   assign head_ready      = alloc_q[head_q] & done_q[head_q];

`ifdef FPNEW_ROB_BYPASS_EN
   assign bypass       = res_hit & (fpu_tag_i == head_q);
   assign rsp_valid_o  = head_ready | bypass;
   assign rsp_result_o = bypass ? fpu_result_i : result_q[head_q];
   assign rsp_status_o = bypass ? fpu_status_i : status_q[head_q];
`else
   assign bypass       = 1'b0;
   assign rsp_valid_o  = head_ready;
   assign rsp_result_o = result_q[head_q];
   assign rsp_status_o = status_q[head_q];
`endif
   assign rsp_user_o = user_q[head_q];

   assign retire = rsp_valid_o & rsp_ready_i;
   // A bypassed head result that is consumed immediately never needs its done bit.
   assign store  = res_hit & ~(bypass & rsp_ready_i);

   always_comb begin
      head_d  = head_q + TagWidth'(retire);
      tail_d  = tail_q + TagWidth'(issue);
      count_d = count_q + CntW'(issue) - CntW'(retire);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         alloc_q    <= '0;
         done_q     <= '0;
         spurious_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (res_bad) spurious_q <= 1'b1;
         if (flush_i) begin
            alloc_q <= '0;
            done_q  <= '0;
         end else begin
            if (retire) begin
               alloc_q[head_q] <= 1'b0;
               done_q[head_q]  <= 1'b0;
            end
            if (issue) begin
               alloc_q[tail_q] <= 1'b1;
               done_q[tail_q]  <= 1'b0;
            end
            if (store) done_q[fpu_tag_i] <= 1'b1;
         end
      end
   end

   // Payload storage needs no reset; alloc/done qualify every read.
   always_ff @(posedge clk_i) begin
      if (issue) user_q[tail_q] <= req_user_i;
      if (store) begin
         result_q[fpu_tag_i] <= fpu_result_i;
         status_q[fpu_tag_i] <= fpu_status_i;
      end
   end

   assign busy_o     = (count_q != '0);
   assign spurious_o = spurious_q;

endmodule

// File: tb/tb_fpnew_rob_issuer.sv
// Directed bench for fpnew_rob_issuer (default build): ordering, full, stall, flush and reset scenarios.
module tb_fpnew_rob_issuer;

   localparam int W = 64;
   localparam int N = 3;
   localparam int D = 4;
   localparam int U = 5;
   localparam int T = 2;

   logic           clk_i = 1'b0;
   logic           rst_i, flush_i;
   logic           req_valid_i, req_ready_o;
   logic [N*W-1:0] req_operands_i;
   logic [2:0]     req_rnd_mode_i;
   logic [3:0]     req_op_i;
   logic           req_op_mod_i;
   logic [2:0]     req_src_fmt_i, req_dst_fmt_i;
   logic [1:0]     req_int_fmt_i;
   logic           req_vectorial_i;
   logic [U-1:0]   req_user_i;
   logic           fpu_valid_o, fpu_ready_i;
   logic [N*W-1:0] fpu_operands_o;
   logic [2:0]     fpu_rnd_mode_o;
   logic [3:0]     fpu_op_o;
   logic           fpu_op_mod_o;
   logic [2:0]     fpu_src_fmt_o, fpu_dst_fmt_o;
   logic [1:0]     fpu_int_fmt_o;
   logic           fpu_vectorial_o;
   logic [T-1:0]   fpu_tag_o;
   logic           fpu_flush_o;
   logic           fpu_out_valid_i, fpu_out_ready_o;
   logic [W-1:0]   fpu_result_i;
   logic [4:0]     fpu_status_i;
   logic [T-1:0]   fpu_tag_i;
   logic           rsp_valid_o, rsp_ready_i;
   logic [W-1:0]   rsp_result_o;
   logic [4:0]     rsp_status_o;
   logic [U-1:0]   rsp_user_o;
   logic           busy_o, spurious_o;

   int checks = 0;
   int errors = 0;

   fpnew_rob_issuer #(.Width(W), .NumOperands(N), .Depth(D), .UserWidth(U)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_operands_i(req_operands_i),
      .req_rnd_mode_i(req_rnd_mode_i), .req_op_i(req_op_i), .req_op_mod_i(req_op_mod_i),
      .req_src_fmt_i(req_src_fmt_i), .req_dst_fmt_i(req_dst_fmt_i), .req_int_fmt_i(req_int_fmt_i),
      .req_vectorial_i(req_vectorial_i), .req_user_i(req_user_i),
      .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_operands_o(fpu_operands_o),
      .fpu_rnd_mode_o(fpu_rnd_mode_o), .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o),
      .fpu_src_fmt_o(fpu_src_fmt_o), .fpu_dst_fmt_o(fpu_dst_fmt_o), .fpu_int_fmt_o(fpu_int_fmt_o),
      .fpu_vectorial_o(fpu_vectorial_o), .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
      .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
      .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
      .rsp_status_o(rsp_status_o), .rsp_user_o(rsp_user_o),
      .busy_o(busy_o), .spurious_o(spurious_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Advance to just after the next rising edge; inputs change and outputs settle before the next edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; fpu_ready_i = 1'b1;
      req_operands_i = '0; req_rnd_mode_i = '0; req_op_i = '0; req_op_mod_i = 1'b0;
      req_src_fmt_i = '0; req_dst_fmt_i = '0; req_int_fmt_i = '0; req_vectorial_i = 1'b0;
      req_user_i = '0; fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_status_i = '0;
      fpu_tag_i = '0; rsp_ready_i = 1'b0;
      tick();
      rst_i = 1'b0;
      #1;
   endtask

   task automatic give_result(input logic [T-1:0] tag, input logic [W-1:0] res, input logic [4:0] st);
      fpu_out_valid_i = 1'b1; fpu_tag_i = tag; fpu_result_i = res; fpu_status_i = st;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
      checks++; if (fpu_valid_o !== 1'b0) begin errors++; $display("FAIL rst_fpu_valid got %b exp 0", fpu_valid_o); end
      checks++; if (spurious_o !== 1'b0) begin errors++; $display("FAIL rst_spurious got %b exp 0", spurious_o); end
      checks++; if (fpu_out_ready_o !== 1'b1) begin errors++; $display("FAIL rst_out_ready got %b exp 1", fpu_out_ready_o); end
   endtask

   task automatic test_single();
      do_reset();
      req_valid_i = 1'b1; req_user_i = 5'd7; req_op_i = 4'd5; req_rnd_mode_i = 3'd2;
      req_operands_i = {64'h1111, 64'h2222, 64'h3333};
      #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL single_req_ready got %b exp 1", req_ready_o); end
      checks++; if (fpu_tag_o !== 2'd0) begin errors++; $display("FAIL single_tag got %0d exp 0", fpu_tag_o); end
      checks++; if (fpu_op_o !== 4'd5 || fpu_rnd_mode_o !== 3'd2) begin errors++; $display("FAIL single_fwd op %0d rm %0d exp 5 2", fpu_op_o, fpu_rnd_mode_o); end
      checks++; if (fpu_operands_o !== {64'h1111, 64'h2222, 64'h3333}) begin errors++; $display("FAIL single_operands got %h", fpu_operands_o); end
      tick();
      req_valid_i = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy_o); end
      tick();
      tick();
      give_result(2'd0, 64'h3FF0000000000000, 5'd0);
      #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", rsp_valid_o); end
      tick();
      fpu_out_valid_i = 1'b0; rsp_ready_i = 1'b1;
      #1;
      checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid_o); end
      checks++; if (rsp_user_o !== 5'd7) begin errors++; $display("FAIL single_user got %0d exp 7", rsp_user_o); end
      checks++; if (rsp_result_o !== 64'h3FF0000000000000) begin errors++; $display("FAIL single_result got %h exp 3ff0000000000000", rsp_result_o); end
      checks++; if (rsp_status_o !== 5'd0) begin errors++; $display("FAIL single_status got %h exp 0", rsp_status_o); end
      tick();
      rsp_ready_i = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain busy %b rsp_valid %b exp 0 0", busy_o, rsp_valid_o); end
   endtask

   task automatic test_out_of_order();
      logic [U-1:0] exp_user [3];
      logic [W-1:0] exp_res  [3];
      logic [4:0]   exp_st   [3];
      exp_user = '{5'd1, 5'd2, 5'd3};
      exp_res  = '{64'hB0B0, 64'hC0C0, 64'hA0A0};
      exp_st   = '{5'd2, 5'd4, 5'd1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req_valid_i = 1'b1; req_user_i = exp_user[i];
         #1;
         checks++; if (fpu_tag_o !== T'(i)) begin errors++; $display("FAIL ooo_tag%0d got %0d exp %0d", i, fpu_tag_o, i); end
         tick();
      end
      req_valid_i = 1'b0;
      give_result(2'd2, 64'hA0A0, 5'd1);
      tick();
      give_result(2'd0, 64'hB0B0, 5'd2);
      #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_head_wait got %b exp 0", rsp_valid_o); end
      tick();
      give_result(2'd1, 64'hC0C0, 5'd4);
      tick();
      fpu_out_valid_i = 1'b0; rsp_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (rsp_valid_o !== 1'b1 || rsp_user_o !== exp_user[i]) begin errors++; $display("FAIL ooo_rsp%0d valid %b user %0d exp 1 %0d", i, rsp_valid_o, rsp_user_o, exp_user[i]); end
         checks++; if (rsp_result_o !== exp_res[i] || rsp_status_o !== exp_st[i]) begin errors++; $display("FAIL ooo_data%0d got %h/%h exp %h/%h", i, rsp_result_o, rsp_status_o, exp_res[i], exp_st[i]); end
         tick();
      end
      rsp_ready_i = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ooo_empty busy got %b exp 0", busy_o); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_valid_i = 1'b1; req_user_i = U'(10 + i);
         #1;
         checks++; if (req_ready_o !== 1'b1 || fpu_tag_o !== T'(i)) begin errors++; $display("FAIL full_fill%0d ready %b tag %0d exp 1 %0d", i, req_ready_o, fpu_tag_o, i); end
         tick();
      end
      req_user_i = 5'd20;
      #1;
      checks++; if (req_ready_o !== 1'b0 || fpu_valid_o !== 1'b0) begin errors++; $display("FAIL full_block ready %b valid %b exp 0 0", req_ready_o, fpu_valid_o); end
      give_result(2'd0, 64'h55, 5'd0);
      tick();
      fpu_out_valid_i = 1'b0; rsp_ready_i = 1'b1;
      #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_user_o !== 5'd10) begin errors++; $display("FAIL full_retire valid %b user %0d exp 1 10", rsp_valid_o, rsp_user_o); end
      checks++; if (fpu_valid_o !== 1'b0) begin errors++; $display("FAIL full_same_cycle got %b exp 0", fpu_valid_o); end
      tick();
      rsp_ready_i = 1'b0;
      #1;
      checks++; if (req_ready_o !== 1'b1 || fpu_tag_o !== 2'd0) begin errors++; $display("FAIL full_reuse ready %b tag %0d exp 1 0", req_ready_o, fpu_tag_o); end
      tick();
      req_valid_i = 1'b0;
      #1;
      checks++; if (fpu_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL full_refill valid %b busy %b exp 0 1", fpu_valid_o, busy_o); end
   endtask

   task automatic test_stall();
      do_reset();
      req_valid_i = 1'b1; fpu_ready_i = 1'b0;
      #1;
      checks++; if (req_ready_o !== 1'b0 || fpu_valid_o !== 1'b1) begin errors++; $display("FAIL stall ready %b valid %b exp 0 1", req_ready_o, fpu_valid_o); end
      tick();
      req_valid_i = 1'b0; fpu_ready_i = 1'b1;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stall_noalloc busy got %b exp 0", busy_o); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req_valid_i = 1'b1; req_user_i = U'(i);
         tick();
      end
      flush_i = 1'b1;
      give_result(2'd0, 64'h77, 5'd0);
      #1;
      checks++; if (fpu_flush_o !== 1'b1) begin errors++; $display("FAIL flush_fwd got %b exp 1", fpu_flush_o); end
      tick();
      flush_i = 1'b0; fpu_out_valid_i = 1'b0; req_valid_i = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear busy %b rsp_valid %b exp 0 0", busy_o, rsp_valid_o); end
      checks++; if (spurious_o !== 1'b0 || fpu_flush_o !== 1'b0) begin errors++; $display("FAIL flush_side spurious %b flush %b exp 0 0", spurious_o, fpu_flush_o); end
      req_valid_i = 1'b1;
      #1;
      checks++; if (fpu_tag_o !== 2'd0) begin errors++; $display("FAIL flush_tag got %0d exp 0", fpu_tag_o); end
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         req_valid_i = 1'b1; req_user_i = U'(i + 4);
         tick();
      end
      req_valid_i = 1'b0;
      give_result(2'd0, 64'h10, 5'd0);
      tick();
      give_result(2'd1, 64'h20, 5'd0);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", rsp_valid_o); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || spurious_o !== 1'b0) begin errors++; $display("FAIL rmid_reset rsp %b busy %b spur %b exp 0 0 0", rsp_valid_o, busy_o, spurious_o); end
      give_result(2'd1, 64'h30, 5'd0);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      checks++; if (spurious_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_spurious spur %b rsp %b exp 1 0", spurious_o, rsp_valid_o); end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
      checks++; if (spurious_o !== 1'b1) begin errors++; $display("FAIL rmid_sticky got %b exp 1", spurious_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_out_of_order();
      test_full();
      test_stall();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
